// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: forwarding codes,
// FSM state encoding and default multiply/divide occupancy.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned FWD_BITS = 2;
  localparam int unsigned CNT_W    = 6;
  localparam int unsigned ST_W     = 1;

  localparam logic [FWD_BITS-1:0] FWD_RF = 2'b00;
  localparam logic [FWD_BITS-1:0] FWD_ME = 2'b01;
  localparam logic [FWD_BITS-1:0] FWD_W  = 2'b10;

  localparam logic [ST_W-1:0] ST_RUN     = 1'b0;
  localparam logic [ST_W-1:0] ST_MD_WAIT = 1'b1;

  localparam int unsigned MUL_LAT_DEF = 4;
  localparam int unsigned DIV_LAT_DEF = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle between the datapath (master) and hazard controller (slave).
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  logic [REG_AW-1:0]   rs_id;
  logic [REG_AW-1:0]   rt_id;
  logic                use_rs_id;
  logic                use_rt_id;
  logic [REG_AW-1:0]   w_addr_e;
  logic                write_e;
  logic                is_lw_e;
  logic [REG_AW-1:0]   w_addr_me;
  logic                write_me;
  logic [REG_AW-1:0]   w_addr_w;
  logic                write_w;
  logic                md_start_id;
  logic                md_div_id;
  logic                jump_id;
  logic                stall;
  logic                flush_if_id;
  logic                bubble_ex;
  logic [FWD_BITS-1:0] fwd_a;
  logic [FWD_BITS-1:0] fwd_b;
  logic                md_busy;

  modport master (
    output rs_id, rt_id, use_rs_id, use_rt_id,
    output w_addr_e, write_e, is_lw_e,
    output w_addr_me, write_me, w_addr_w, write_w,
    output md_start_id, md_div_id, jump_id,
    input  stall, flush_if_id, bubble_ex, fwd_a, fwd_b, md_busy
  );

  modport slave (
    input  rs_id, rt_id, use_rs_id, use_rt_id,
    input  w_addr_e, write_e, is_lw_e,
    input  w_addr_me, write_me, w_addr_w, write_w,
    input  md_start_id, md_div_id, jump_id,
    output stall, flush_if_id, bubble_ex, fwd_a, fwd_b, md_busy
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand forwarding select: MEM result wins over WB result; $0 never forwards.
module fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0]   i_rs,
  input  logic [REG_AW-1:0]   i_rt,
  input  logic [REG_AW-1:0]   i_w_addr_me,
  input  logic                i_write_me,
  input  logic [REG_AW-1:0]   i_w_addr_w,
  input  logic                i_write_w,
  output logic [FWD_BITS-1:0] o_fwd_a,
  output logic [FWD_BITS-1:0] o_fwd_b
);

  logic w_me_valid;
  logic w_w_valid;

  assign w_me_valid = i_write_me && (i_w_addr_me != '0);
  assign w_w_valid  = i_write_w  && (i_w_addr_w  != '0);

  // Source select for both operands, nearest producer first
  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (w_me_valid && (i_w_addr_me == i_rs))     o_fwd_a = FWD_ME;
    else if (w_w_valid && (i_w_addr_w == i_rs))  o_fwd_a = FWD_W;
    if (w_me_valid && (i_w_addr_me == i_rt))     o_fwd_b = FWD_ME;
    else if (w_w_valid && (i_w_addr_w == i_rt))  o_fwd_b = FWD_W;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle mul/div occupancy,
// jump flush and operand forwarding selection.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  pipe_hazard_ctrl_if.slave bus
);

  logic [ST_W-1:0]  r_state;
  logic [CNT_W-1:0] r_md_cnt;
  logic             r_md_busy;

  logic [ST_W-1:0]  w_state_nxt;
  logic [CNT_W-1:0] w_md_cnt_nxt;
  logic             w_md_busy_nxt;
  logic             w_load_use;
  logic             w_stall;
  logic             w_bubble;

  // Load in EX whose destination is read by the ID instruction
  always_comb begin
    w_load_use = bus.is_lw_e && bus.write_e && (bus.w_addr_e != '0) &&
                 ((bus.use_rs_id && (bus.rs_id == bus.w_addr_e)) ||
                  (bus.use_rt_id && (bus.rt_id == bus.w_addr_e)));
  end

  // State, occupancy counter and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_RUN;
      r_md_cnt  <= '0;
      r_md_busy <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_md_cnt  <= w_md_cnt_nxt;
      r_md_busy <= w_md_busy_nxt;
    end
  end

  // Next state and stall/bubble; MD_WAIT outranks load-use, which outranks issue
  always_comb begin
    w_state_nxt  = r_state;
    w_md_cnt_nxt = r_md_cnt;
    w_stall      = 1'b0;
    w_bubble     = 1'b0;
    case (r_state)
      ST_MD_WAIT: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        if (r_md_cnt == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_md_cnt_nxt = r_md_cnt - CNT_W'(1);
        end
      end
      default: begin
        if (w_load_use) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end else if (bus.md_start_id) begin
          w_state_nxt  = ST_MD_WAIT;
          w_md_cnt_nxt = bus.md_div_id ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
        end
      end
    endcase
    w_md_busy_nxt = (w_state_nxt == ST_MD_WAIT);
  end

  fwd_unit u_fwd (
    .i_rs        (bus.rs_id),
    .i_rt        (bus.rt_id),
    .i_w_addr_me (bus.w_addr_me),
    .i_write_me  (bus.write_me),
    .i_w_addr_w  (bus.w_addr_w),
    .i_write_w   (bus.write_w),
    .o_fwd_a     (bus.fwd_a),
    .o_fwd_b     (bus.fwd_b)
  );

  assign bus.stall       = w_stall;
  assign bus.bubble_ex   = w_bubble;
  assign bus.flush_if_id = bus.jump_id && !w_stall;
  assign bus.md_busy     = r_md_busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.rs_id = 5'd0;  bus.rt_id = 5'd0;
    bus.use_rs_id = 1'b0; bus.use_rt_id = 1'b0;
    bus.w_addr_e = 5'd0; bus.write_e = 1'b0; bus.is_lw_e = 1'b0;
    bus.w_addr_me = 5'd0; bus.write_me = 1'b0;
    bus.w_addr_w = 5'd0; bus.write_w = 1'b0;
    bus.md_start_id = 1'b0; bus.md_div_id = 1'b0; bus.jump_id = 1'b0;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] ref_fwd(input int src, input bit wme, input int ame,
                                         input bit ww, input int aw);
    if (wme && ame != 0 && ame == src) return 2'b01;
    if (ww && aw != 0 && aw == src) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    n_tests++;
    if ({bus.stall, bus.bubble_ex, bus.md_busy, bus.flush_if_id} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0000",
               {bus.stall, bus.bubble_ex, bus.md_busy, bus.flush_if_id});
    end
    @(negedge clk);
    rst = 1'b0;
    sync();
  endtask

  task automatic test_load_use();
    sync();
    bus.is_lw_e = 1'b1; bus.write_e = 1'b1; bus.w_addr_e = 5'd5;
    bus.rs_id = 5'd5; bus.use_rs_id = 1'b1; bus.rt_id = 5'd2; bus.use_rt_id = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.stall, bus.bubble_ex} !== 2'b11) begin
      n_fail++;
      $display("FAIL lu_stall: got %b expected 11", {bus.stall, bus.bubble_ex});
    end
    sync();
    // lw now in MEM, bubble in EX
    bus.is_lw_e = 1'b0; bus.write_e = 1'b0; bus.w_addr_e = 5'd0;
    bus.write_me = 1'b1; bus.w_addr_me = 5'd5;
    @(negedge clk);
    n_tests++;
    if ({bus.stall, bus.bubble_ex, bus.fwd_a} !== 4'b0001) begin
      n_fail++;
      $display("FAIL lu_release: got %b expected 0001", {bus.stall, bus.bubble_ex, bus.fwd_a});
    end
    sync();
    // lw in WB, bubble in MEM
    bus.write_me = 1'b0; bus.w_addr_me = 5'd0;
    bus.write_w = 1'b1; bus.w_addr_w = 5'd5;
    @(negedge clk);
    n_tests++;
    if (bus.fwd_a !== 2'b10) begin
      n_fail++;
      $display("FAIL lu_wb_fwd: got %b expected 10", bus.fwd_a);
    end
    idle_inputs();
  endtask

  task automatic count_busy(input string name, input int expected, input int drop_at);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.md_busy) break;
      cnt++;
      n_tests++;
      if ({bus.stall, bus.bubble_ex, bus.flush_if_id} !== 3'b110) begin
        n_fail++;
        $display("FAIL %s_hold: cycle %0d got %b expected 110", name, i,
                 {bus.stall, bus.bubble_ex, bus.flush_if_id});
      end
      if (i == drop_at) begin
        bus.md_start_id = 1'b0;
        bus.jump_id = 1'b0;
      end
      sync();
    end
    n_tests++;
    if (cnt != expected) begin
      n_fail++;
      $display("FAIL %s_len: got %0d cycles expected %0d", name, cnt, expected);
    end
  endtask

  task automatic test_mul();
    sync();
    bus.md_start_id = 1'b1; bus.md_div_id = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.stall, bus.md_busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL mul_issue: got %b expected 00", {bus.stall, bus.md_busy});
    end
    sync();
    // md_start_id and a jump stay asserted for a while during MD_WAIT
    bus.jump_id = 1'b1;
    count_busy("mul", 4, 1);
    idle_inputs();
  endtask

  task automatic test_div_load_use();
    sync();
    bus.is_lw_e = 1'b1; bus.write_e = 1'b1; bus.w_addr_e = 5'd9;
    bus.rt_id = 5'd9; bus.use_rt_id = 1'b1;
    bus.md_start_id = 1'b1; bus.md_div_id = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.stall, bus.bubble_ex, bus.md_busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL div_lu_bubble: got %b expected 110", {bus.stall, bus.bubble_ex, bus.md_busy});
    end
    sync();
    bus.is_lw_e = 1'b0; bus.write_e = 1'b0; bus.w_addr_e = 5'd0;
    @(negedge clk);
    n_tests++;
    if ({bus.stall, bus.bubble_ex, bus.md_busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL div_issue: got %b expected 000", {bus.stall, bus.bubble_ex, bus.md_busy});
    end
    sync();
    bus.md_start_id = 1'b0;
    count_busy("div", 32, -1);
    idle_inputs();
  endtask

  task automatic test_fwd();
    sync();
    bus.write_me = 1'b1; bus.w_addr_me = 5'd7;
    bus.write_w = 1'b1; bus.w_addr_w = 5'd7;
    bus.rs_id = 5'd7; bus.rt_id = 5'd7;
    #1;
    n_tests++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b0101) begin
      n_fail++;
      $display("FAIL fwd_me_prio: got %b expected 0101", {bus.fwd_a, bus.fwd_b});
    end
    bus.write_me = 1'b0; bus.rt_id = 5'd3;
    #1;
    n_tests++;
    if ({bus.fwd_a, bus.fwd_b} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fwd_wb_only: got %b expected 1000", {bus.fwd_a, bus.fwd_b});
    end
    bus.write_me = 1'b1; bus.w_addr_me = 5'd0; bus.w_addr_w = 5'd0;
    bus.rs_id = 5'd0; bus.rt_id = 5'd0;
    bus.is_lw_e = 1'b1; bus.write_e = 1'b1; bus.w_addr_e = 5'd0;
    bus.use_rs_id = 1'b1; bus.use_rt_id = 1'b1;
    #1;
    n_tests++;
    if ({bus.fwd_a, bus.fwd_b, bus.stall} !== 5'b00000) begin
      n_fail++;
      $display("FAIL fwd_r0: got %b expected 00000", {bus.fwd_a, bus.fwd_b, bus.stall});
    end
    idle_inputs();
  endtask

  task automatic test_jump_stall();
    sync();
    bus.is_lw_e = 1'b1; bus.write_e = 1'b1; bus.w_addr_e = 5'd4;
    bus.rs_id = 5'd4; bus.use_rs_id = 1'b1; bus.jump_id = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.stall, bus.flush_if_id} !== 2'b10) begin
      n_fail++;
      $display("FAIL jump_in_stall: got %b expected 10", {bus.stall, bus.flush_if_id});
    end
    sync();
    bus.is_lw_e = 1'b0; bus.write_e = 1'b0; bus.w_addr_e = 5'd0;
    @(negedge clk);
    n_tests++;
    if ({bus.stall, bus.flush_if_id} !== 2'b01) begin
      n_fail++;
      $display("FAIL jump_after_stall: got %b expected 01", {bus.stall, bus.flush_if_id});
    end
    idle_inputs();
  endtask

  task automatic test_rst_mid_div();
    sync();
    bus.md_start_id = 1'b1; bus.md_div_id = 1'b1;
    sync();
    bus.md_start_id = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({bus.md_busy, bus.stall} !== 2'b11) begin
      n_fail++;
      $display("FAIL rst_pre_busy: got %b expected 11", {bus.md_busy, bus.stall});
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.md_busy, bus.stall, bus.bubble_ex} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_abort: got %b expected 000", {bus.md_busy, bus.stall, bus.bubble_ex});
    end
    #1;
    rst = 1'b0;
    sync();
    @(negedge clk);
    n_tests++;
    if ({bus.md_busy, bus.stall} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_after: got %b expected 00", {bus.md_busy, bus.stall});
    end
  endtask

  task automatic test_random();
    int busy_left;
    bit lu;
    bit exp_stall;
    logic [7:0] exp_v;
    logic [7:0] got_v;
    busy_left = 0;
    sync();
    for (int c = 0; c < 800; c++) begin
      bus.rs_id = 5'($urandom_range(0, 3));
      bus.rt_id = 5'($urandom_range(0, 3));
      bus.use_rs_id = 1'($urandom_range(0, 1));
      bus.use_rt_id = 1'($urandom_range(0, 1));
      bus.w_addr_e = 5'($urandom_range(0, 3));
      bus.write_e = 1'($urandom_range(0, 1));
      bus.is_lw_e = 1'($urandom_range(0, 1));
      bus.w_addr_me = 5'($urandom_range(0, 3));
      bus.write_me = 1'($urandom_range(0, 1));
      bus.w_addr_w = 5'($urandom_range(0, 3));
      bus.write_w = 1'($urandom_range(0, 1));
      bus.md_start_id = ($urandom_range(0, 11) == 0);
      bus.md_div_id = ($urandom_range(0, 3) == 0);
      bus.jump_id = 1'($urandom_range(0, 1));
      lu = bus.is_lw_e && bus.write_e && bus.w_addr_e != 0 &&
           ((bus.use_rs_id && bus.rs_id == bus.w_addr_e) ||
            (bus.use_rt_id && bus.rt_id == bus.w_addr_e));
      exp_stall = (busy_left > 0) || lu;
      exp_v = {exp_stall, exp_stall, bus.jump_id && !exp_stall,
               ref_fwd(int'(bus.rs_id), bus.write_me, int'(bus.w_addr_me), bus.write_w, int'(bus.w_addr_w)),
               ref_fwd(int'(bus.rt_id), bus.write_me, int'(bus.w_addr_me), bus.write_w, int'(bus.w_addr_w)),
               busy_left > 0};
      @(negedge clk);
      got_v = {bus.stall, bus.bubble_ex, bus.flush_if_id, bus.fwd_a, bus.fwd_b, bus.md_busy};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got %b expected %b (stall,bub,flush,fa,fb,busy)",
                 c, got_v, exp_v);
      end
      @(posedge clk);
      if (busy_left > 0) busy_left--;
      else if (bus.md_start_id && !lu) busy_left = bus.md_div_id ? 32 : 4;
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load_use();
    test_mul();
    test_div_load_use();
    test_fwd();
    test_jump_stall();
    test_rst_mid_div();
    test_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
